cache_bus_arbiter: RTL and testbench

Shares one cache bus unit between two cache controllers: port 0 is the I-cache and port 1 is the D-cache. Each port presents single-read, line-read and write-through requests. The block grants one port at a time using round-robin arbitration, forwards the granted port's request, address and data to the bus unit, and routes completion, error and line-fill signals back to that port only. It sits between the cache controllers and the bus unit, on the cache side of the AHB master.

---
 rtl/cache_bus_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 21 ++
 rtl/cache_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_cache_bus_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_bus_pkg.sv
// Shared definitions for the cache bus arbiter: FSM states, port indices
// and the line-beat counter width derivation.
package cache_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Port 0 is the I-cache, port 1 is the D-cache.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int MAX_BURST_DEFAULT = 256;

    // Width of the line beat index; a one-beat line still needs one bit.
    function automatic int burst_wid(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker. On a tie the requester that was not
// granted last time wins. Purely combinational; the caller owns last_gnt.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    // Pick a one-hot winner from the live requests.
    always_comb begin
        // NOTE: gnt gets a default before the case so every path assigns it and no latch is inferred.
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one cache bus unit between the I-cache (port 0) and the D-cache
// (port 1). A port is granted from IDLE, keeps the bus until the bus unit
// reports completion or error, then a one-cycle RELEASE guarantees the bus
// unit never sees a stale request before the next arbitration.
module cache_bus_arbiter
    import cache_bus_pkg::*;
#(
    parameter  int BUS_WIDTH = 8,
    parameter  int BUS_ADDR  = 24,
    parameter  int MAX_BURST = MAX_BURST_DEFAULT,
    localparam int BURST_WID = burst_wid(MAX_BURST)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_read_req,
    input  logic                 m0_read_line_req,
    input  logic                 m0_write_through_req,
    input  logic [BUS_ADDR-1:0]  m0_pa,
    input  logic [BUS_WIDTH-1:0] m0_wt_data,
    output logic [BUS_WIDTH-1:0] m0_line_data,
    output logic [BURST_WID-1:0] m0_addr_count,
    output logic                 m0_line_write,
    output logic                 m0_trans_rdy,
    output logic                 m0_bus_error,

    input  logic                 m1_read_req,
    input  logic                 m1_read_line_req,
    input  logic                 m1_write_through_req,
    input  logic [BUS_ADDR-1:0]  m1_pa,
    input  logic [BUS_WIDTH-1:0] m1_wt_data,
    output logic [BUS_WIDTH-1:0] m1_line_data,
    output logic [BURST_WID-1:0] m1_addr_count,
    output logic                 m1_line_write,
    output logic                 m1_trans_rdy,
    output logic                 m1_bus_error,

    output logic [1:0]           grant,

    output logic                 bu_read_req,
    output logic                 bu_read_line_req,
    output logic                 bu_write_through_req,
    output logic [BUS_ADDR-1:0]  bu_pa,
    output logic [BUS_WIDTH-1:0] bu_wt_data,
    input  logic [BUS_WIDTH-1:0] bu_line_data,
    input  logic [BURST_WID-1:0] bu_addr_count,
    input  logic                 bu_line_write,
    input  logic                 bu_trans_rdy,
    input  logic                 bu_bus_error
);

    state_t     state, state_nxt;
    logic [1:0] grant_nxt;
    logic       last_gnt, last_gnt_nxt;
    logic [1:0] req_any;
    logic [1:0] arb_gnt;
    logic       done;

    assign req_any[PORT_I] = m0_read_req | m0_read_line_req | m0_write_through_req;
    assign req_any[PORT_D] = m1_read_req | m1_read_line_req | m1_write_through_req;
    assign done            = bu_trans_rdy | bu_bus_error;

    rr_arbiter2 u_rr_arbiter2 (
        .req      (req_any),
        .last_gnt (last_gnt),
        .gnt      (arb_gnt)
    );

    // State, grant and round-robin history registers; reset may land mid-transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= 2'b00;
            last_gnt <= PORT_D;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state    <= state_nxt;
            grant    <= grant_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until completion, drop it for RELEASE.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        last_gnt_nxt = last_gnt;
        case (state)
            ST_IDLE: begin
                if (|req_any) begin
                    state_nxt    = ST_BUSY;
                    grant_nxt    = arb_gnt;
                    last_gnt_nxt = arb_gnt[PORT_D];
                end
            end
            ST_BUSY: begin
                if (done) begin
                    state_nxt = ST_RELEASE;
                    grant_nxt = 2'b00;
                end
            end
            ST_RELEASE: begin
                state_nxt = ST_IDLE;
                grant_nxt = 2'b00;
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    // Forward the owner's live request, address and data; everything is zero without a grant.
    always_comb begin
        bu_read_req          = 1'b0;
        bu_read_line_req     = 1'b0;
        bu_write_through_req = 1'b0;
        bu_pa                = '0;
        bu_wt_data           = '0;
        if (grant[PORT_I]) begin
            bu_read_req          = m0_read_req;
            bu_read_line_req     = m0_read_line_req;
            bu_write_through_req = m0_write_through_req;
            bu_pa                = m0_pa;
            bu_wt_data           = m0_wt_data;
        end else if (grant[PORT_D]) begin
            bu_read_req          = m1_read_req;
            bu_read_line_req     = m1_read_line_req;
            bu_write_through_req = m1_write_through_req;
            bu_pa                = m1_pa;
            bu_wt_data           = m1_wt_data;
        end
    end

    // Responses reach the owner only, with zero latency; data and beat index fan out to both.
    assign m0_trans_rdy  = bu_trans_rdy  & grant[PORT_I];
    assign m0_bus_error  = bu_bus_error  & grant[PORT_I];
    assign m0_line_write = bu_line_write & grant[PORT_I];
    assign m1_trans_rdy  = bu_trans_rdy  & grant[PORT_D];
    assign m1_bus_error  = bu_bus_error  & grant[PORT_D];
    assign m1_line_write = bu_line_write & grant[PORT_D];

    assign m0_line_data  = bu_line_data;
    assign m1_line_data  = bu_line_data;
    assign m0_addr_count = bu_addr_count;
    assign m1_addr_count = bu_addr_count;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: a transaction-level model of
// bus ownership is compared against the DUT on every falling edge, and
// directed scenarios add hand-computed literal expectations.
module tb_cache_bus_arbiter;

    localparam int BUS_WIDTH = 8;
    localparam int BUS_ADDR  = 24;
    localparam int MAX_BURST = 256;
    localparam int BURST_WID = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 m0_read_req, m0_read_line_req, m0_write_through_req;
    logic [BUS_ADDR-1:0]  m0_pa;
    logic [BUS_WIDTH-1:0] m0_wt_data;
    logic [BUS_WIDTH-1:0] m0_line_data;
    logic [BURST_WID-1:0] m0_addr_count;
    logic                 m0_line_write, m0_trans_rdy, m0_bus_error;
    logic                 m1_read_req, m1_read_line_req, m1_write_through_req;
    logic [BUS_ADDR-1:0]  m1_pa;
    logic [BUS_WIDTH-1:0] m1_wt_data;
    logic [BUS_WIDTH-1:0] m1_line_data;
    logic [BURST_WID-1:0] m1_addr_count;
    logic                 m1_line_write, m1_trans_rdy, m1_bus_error;
    logic [1:0]           grant;
    logic                 bu_read_req, bu_read_line_req, bu_write_through_req;
    logic [BUS_ADDR-1:0]  bu_pa;
    logic [BUS_WIDTH-1:0] bu_wt_data;
    logic [BUS_WIDTH-1:0] bu_line_data;
    logic [BURST_WID-1:0] bu_addr_count;
    logic                 bu_line_write, bu_trans_rdy, bu_bus_error;

    int tests = 0;
    int fails = 0;

    cache_bus_arbiter #(
        .BUS_WIDTH (BUS_WIDTH),
        .BUS_ADDR  (BUS_ADDR),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .m0_read_req          (m0_read_req),
        .m0_read_line_req     (m0_read_line_req),
        .m0_write_through_req (m0_write_through_req),
        .m0_pa                (m0_pa),
        .m0_wt_data           (m0_wt_data),
        .m0_line_data         (m0_line_data),
        .m0_addr_count        (m0_addr_count),
        .m0_line_write        (m0_line_write),
        .m0_trans_rdy         (m0_trans_rdy),
        .m0_bus_error         (m0_bus_error),
        .m1_read_req          (m1_read_req),
        .m1_read_line_req     (m1_read_line_req),
        .m1_write_through_req (m1_write_through_req),
        .m1_pa                (m1_pa),
        .m1_wt_data           (m1_wt_data),
        .m1_line_data         (m1_line_data),
        .m1_addr_count        (m1_addr_count),
        .m1_line_write        (m1_line_write),
        .m1_trans_rdy         (m1_trans_rdy),
        .m1_bus_error         (m1_bus_error),
        .grant                (grant),
        .bu_read_req          (bu_read_req),
        .bu_read_line_req     (bu_read_line_req),
        .bu_write_through_req (bu_write_through_req),
        .bu_pa                (bu_pa),
        .bu_wt_data           (bu_wt_data),
        .bu_line_data         (bu_line_data),
        .bu_addr_count        (bu_addr_count),
        .bu_line_write        (bu_line_write),
        .bu_trans_rdy         (bu_trans_rdy),
        .bu_bus_error         (bu_bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- ownership model ----------------
    // m_owner: -1 when nobody owns the bus, else the port number.
    // m_cool:  one dead cycle after a completion before arbitration resumes.
    // m_last:  port that won most recently; a tie goes to the other one.
    int m_owner;
    bit m_cool;
    bit m_last;

    wire any0 = m0_read_req | m0_read_line_req | m0_write_through_req;
    wire any1 = m1_read_req | m1_read_line_req | m1_write_through_req;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1;
            m_cool  <= 1'b0;
            m_last  <= 1'b1;
        end else if (m_owner >= 0) begin
            if (bu_trans_rdy || bu_bus_error) begin
                m_owner <= -1;
                m_cool  <= 1'b1;
            end
        end else if (m_cool) begin
            m_cool <= 1'b0;
        end else if (any0 && any1) begin
            m_owner <= m_last ? 0 : 1;
            m_last  <= ~m_last;
        end else if (any0) begin
            m_owner <= 0;
            m_last  <= 1'b0;
        end else if (any1) begin
            m_owner <= 1;
            m_last  <= 1'b1;
        end
    end

    wire own0 = (m_owner == 0);
    wire own1 = (m_owner == 1);

    wire [1:0]          e_grant = {own1, own0};
    wire [2:0]          e_req   = own0 ? {m0_read_req, m0_read_line_req, m0_write_through_req} :
                                  own1 ? {m1_read_req, m1_read_line_req, m1_write_through_req} : 3'b000;
    wire [BUS_ADDR-1:0] e_pa    = own0 ? m0_pa : own1 ? m1_pa : '0;
    wire [BUS_WIDTH-1:0] e_wt   = own0 ? m0_wt_data : own1 ? m1_wt_data : '0;
    wire [2:0]          e_r0    = own0 ? {bu_trans_rdy, bu_bus_error, bu_line_write} : 3'b000;
    wire [2:0]          e_r1    = own1 ? {bu_trans_rdy, bu_bus_error, bu_line_write} : 3'b000;

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        check("cmp grant", 32'(grant), 32'(e_grant));
        check("cmp bu_req", 32'({bu_read_req, bu_read_line_req, bu_write_through_req}), 32'(e_req));
        check("cmp bu_pa", 32'(bu_pa), 32'(e_pa));
        check("cmp bu_wt_data", 32'(bu_wt_data), 32'(e_wt));
        check("cmp m0_resp", 32'({m0_trans_rdy, m0_bus_error, m0_line_write}), 32'(e_r0));
        check("cmp m1_resp", 32'({m1_trans_rdy, m1_bus_error, m1_line_write}), 32'(e_r1));
        check("cmp line_data", 32'({m0_line_data, m1_line_data}), 32'({bu_line_data, bu_line_data}));
        check("cmp addr_count", 32'({m0_addr_count, m1_addr_count}), 32'({bu_addr_count, bu_addr_count}));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_port(input int port);
        if (port == 0) begin
            m0_read_req = 1'b0; m0_read_line_req = 1'b0; m0_write_through_req = 1'b0;
        end else begin
            m1_read_req = 1'b0; m1_read_line_req = 1'b0; m1_write_through_req = 1'b0;
        end
    endtask

    // Bus unit ends the owner's transaction; the owner may drop its request on the ack edge.
    task automatic finish_txn(input int port, input bit err, input bit drop);
        if (err) bu_bus_error = 1'b1;
        else     bu_trans_rdy = 1'b1;
        #1;
        if (port == 0)
            check("done route p0", 32'({m0_trans_rdy, m0_bus_error, m1_trans_rdy, m1_bus_error}),
                  err ? 32'h4 : 32'h8);
        else
            check("done route p1", 32'({m0_trans_rdy, m0_bus_error, m1_trans_rdy, m1_bus_error}),
                  err ? 32'h1 : 32'h2);
        tick();
        bu_trans_rdy = 1'b0;
        bu_bus_error = 1'b0;
        if (drop) clear_port(port);
    endtask

    task automatic wait_grant(input logic [1:0] exp, input int budget, input string name);
        int n = 0;
        while (grant !== exp && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(grant), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int good;
        int bad;
        rst = 1'b1;
        m0_read_req = 0; m0_read_line_req = 0; m0_write_through_req = 0; m0_pa = '0; m0_wt_data = '0;
        m1_read_req = 0; m1_read_line_req = 0; m1_write_through_req = 0; m1_pa = '0; m1_wt_data = '0;
        bu_line_data = '0; bu_addr_count = '0; bu_line_write = 0; bu_trans_rdy = 0; bu_bus_error = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("reset grant", 32'(grant), 32'h0);
        check("reset bu_req", 32'({bu_read_req, bu_read_line_req, bu_write_through_req}), 32'h0);

        // Single read on port 0.
        tick();
        m0_pa = 24'h001234; m0_read_req = 1'b1;
        tick();
        check("t1 grant", 32'(grant), 32'h1);
        check("t1 bu_read_req", 32'(bu_read_req), 32'h1);
        check("t1 bu_pa", 32'(bu_pa), 32'h001234);
        finish_txn(0, 1'b0, 1'b1);
        #1;
        check("t1 release grant", 32'(grant), 32'h0);
        check("t1 release bu_read_req", 32'(bu_read_req), 32'h0);

        // Tie right after reset: port 0 first, then port 1 after RELEASE and IDLE.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_pa = 24'hA0A0A0; m1_pa = 24'h0B0B0B;
        m0_read_req = 1'b1; m1_read_req = 1'b1;
        tick();
        check("t2 first grant", 32'(grant), 32'h1);
        check("t2 first bu_pa", 32'(bu_pa), 32'hA0A0A0);
        finish_txn(0, 1'b0, 1'b1);
        check("t2 release grant", 32'(grant), 32'h0);
        tick();
        check("t2 idle grant", 32'(grant), 32'h0);
        tick();
        check("t2 second grant", 32'(grant), 32'h2);
        check("t2 second bu_pa", 32'(bu_pa), 32'h0B0B0B);
        finish_txn(1, 1'b0, 1'b1);

        // Full 256-beat line fill on port 1.
        m1_pa = 24'h00FF00; m1_read_line_req = 1'b1;
        wait_grant(2'b10, 4, "t3 grant");
        check("t3 bu_read_line_req", 32'(bu_read_line_req), 32'h1);
        good = 0;
        bad  = 0;
        for (int i = 0; i < MAX_BURST; i++) begin
            bu_line_write = 1'b1;
            bu_addr_count = 8'(i);
            bu_line_data  = 8'(i) ^ 8'h5A;
            #1;
            if (m1_line_write === 1'b1 && m1_addr_count === 8'(i) && m1_line_data === (8'(i) ^ 8'h5A))
                good++;
            if (m0_line_write !== 1'b0)
                bad++;
            tick();
        end
        bu_line_write = 1'b0;
        check("t3 m1 beats", 32'(good), 32'd256);
        check("t3 m0 stray beats", 32'(bad), 32'd0);
        finish_txn(1, 1'b0, 1'b1);

        // Error on port 0 while port 1 waits; port 1 follows two cycles later.
        m0_pa = 24'h00C0DE; m0_wt_data = 8'h3C; m0_write_through_req = 1'b1;
        m1_pa = 24'h111111; m1_read_req = 1'b1;
        wait_grant(2'b01, 4, "t4 grant p0");
        check("t4 bu_req", 32'({bu_read_req, bu_read_line_req, bu_write_through_req}), 32'h1);
        check("t4 bu_wt_data", 32'(bu_wt_data), 32'h3C);
        finish_txn(0, 1'b1, 1'b1);
        check("t4 release grant", 32'(grant), 32'h0);
        tick();
        check("t4 idle grant", 32'(grant), 32'h0);
        tick();
        check("t4 grant p1", 32'(grant), 32'h2);
        check("t4 bu_pa p1", 32'(bu_pa), 32'h111111);
        finish_txn(1, 1'b0, 1'b1);

        // Fairness: port 0 requests back to back, port 1 joins mid-transaction.
        m0_pa = 24'h000100; m0_read_req = 1'b1;
        wait_grant(2'b01, 4, "t5 grant p0");
        tick();
        m1_pa = 24'h222222; m1_read_req = 1'b1;
        tick();
        finish_txn(0, 1'b0, 1'b0);
        tick();
        tick();
        check("t5 grant p1", 32'(grant), 32'h2);
        finish_txn(1, 1'b0, 1'b1);
        wait_grant(2'b01, 4, "t5 regrant p0");
        finish_txn(0, 1'b0, 1'b1);

        // Completion strobes while idle must not reach either port.
        tick();
        bu_trans_rdy = 1'b1; bu_bus_error = 1'b1; bu_line_write = 1'b1;
        #1;
        check("t6 idle resp", 32'({m0_trans_rdy, m0_bus_error, m0_line_write,
                                   m1_trans_rdy, m1_bus_error, m1_line_write}), 32'h0);
        tick();
        bu_trans_rdy = 1'b0; bu_bus_error = 1'b0; bu_line_write = 1'b0;
        check("t6 idle grant", 32'(grant), 32'h0);

        // Asynchronous reset in the middle of a BUSY transaction.
        m0_pa = 24'h0ABCDE; m0_read_req = 1'b1;
        wait_grant(2'b01, 4, "t7 grant p0");
        #2;
        rst = 1'b1;
        #1;
        check("t7 async grant", 32'(grant), 32'h0);
        check("t7 async bu_req", 32'({bu_read_req, bu_read_line_req, bu_write_through_req}), 32'h0);
        check("t7 async bu_pa", 32'(bu_pa), 32'h0);
        m1_pa = 24'h333333; m1_read_req = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t7 tie after reset", 32'(grant), 32'h1);
        finish_txn(0, 1'b0, 1'b1);
        wait_grant(2'b10, 4, "t7 grant p1");
        check("t7 bu_pa p1", 32'(bu_pa), 32'h333333);
        finish_txn(1, 1'b0, 1'b1);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
